// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    typedef enum logic [1:0] {
        LdIdle,
        LdBusy,
        LdDone,
        LdError
    } status_e;

    // Collapse an FSM state into the externally visible load status.
    function automatic status_e status_of(state_e s);
        case (s)
            StIdle:  return LdIdle;
            StDone:  return LdDone;
            StErr:   return LdError;
            default: return LdBusy;
        endcase
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles big-endian bytes into words; pulses word_valid_o the cycle after the last byte.
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);

    localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;

    // Shift bytes in MSB first and flag completion of each word.
    always_comb begin
        cnt_d        = cnt_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (byte_valid_i) begin
            word_d       = {word_q[DATA_W-9:0], byte_data_i};
            cnt_d        = cnt_q + 1'b1;
            word_valid_d = (cnt_q == CntW'(BYTES_PER_WORD - 1));
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory and
// holds the CPU until a good load completes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    // Length byte limit; DEPTH must fit in a byte.
    localparam logic [7:0] DepthByte = 8'(DEPTH);

    state_e          state_q, state_d;
    logic [ADDR_W:0] n_q, n_d;
    logic [ADDR_W:0] word_count_q, word_count_d;
    logic [7:0]      chk_q, chk_d;
    logic            byte_ready_q, byte_ready_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic            accept;
    logic            pk_valid;
    logic            pk_clear;
    logic            word_valid;
    logic            last_write;
    logic [DATA_W-1:0] word;

    assign accept = byte_valid & byte_ready_q;
    // Write cycle of the final word: a byte accepted now is the checksum.
    assign last_write = word_valid && ((word_count_q + 1'b1) == n_q);

    imem_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_data_i  (byte_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Next-state logic for the load FSM, word counter and checksum.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        chk_d        = chk_q;
        word_count_d = word_count_q;
        pk_valid     = 1'b0;
        pk_clear     = 1'b0;
        // Word index advances at the end of each write cycle.
        if (word_valid) begin
            word_count_d = word_count_q + 1'b1;
        end
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d      = StLen;
                    word_count_d = '0;
                    pk_clear     = 1'b1;
                end
            end
            StLen: begin
                if (accept) begin
                    if (byte_data == 8'd0 || byte_data > DepthByte) begin
                        state_d = StErr;
                    end else begin
                        n_d          = byte_data[ADDR_W:0];
                        chk_d        = 8'd0;
                        word_count_d = '0;
                        state_d      = StData;
                    end
                end
            end
            StData: begin
                if (last_write) begin
                    if (accept) begin
                        state_d = (byte_data == chk_q) ? StDone : StErr;
                    end else begin
                        state_d = StChk;
                    end
                end else if (accept) begin
                    pk_valid = 1'b1;
                    chk_d    = chk_q ^ byte_data;
                end
            end
            StChk: begin
                if (accept) begin
                    state_d = (byte_data == chk_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs decoded from the next state.
    always_comb begin
        byte_ready_d = (state_d == StLen) || (state_d == StData) || (state_d == StChk);
        done_d       = (status_of(state_d) == LdDone);
        error_d      = (status_of(state_d) == LdError);
        cpu_hold_d   = !done_d;
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            n_q          <= '0;
            chk_q        <= 8'd0;
            word_count_q <= '0;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            chk_q        <= chk_d;
            word_count_q <= word_count_d;
            byte_ready_q <= byte_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = word_valid;
    assign mem_addr   = word_count_q[ADDR_W-1:0];
    assign mem_wdata  = word;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [6:0]  word_count;

    int tests;
    int fails;
    int cyc;

    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] shadow[64];

    imem_loader #(
        .ADDR_W (6),
        .DATA_W (32),
        .DEPTH  (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: log and store every write strobe.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            shadow[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks are entered and left at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (byte_ready !== 1'b1) begin
            fails++;
            $display("FAIL byte_timeout: byte_ready=%b required 1", byte_ready);
        end
        @(negedge clk);
    endtask

    task automatic stop_bytes();
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    function automatic logic [7:0] xor_word(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    task automatic test_reset();
        tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_hold: got %b want 1", cpu_hold); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
        tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", mem_we); end
        tests++; if (word_count !== 7'd0) begin fails++; $display("FAIL reset_wc: got %0d want 0", word_count); end
        tests++; if (mem_wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        tests++; if (mem_addr !== 6'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    endtask

    task automatic test_bad_checksum();
        wr_addr.delete(); wr_data.delete();
        do_start();
        tests++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL start_ready: got %b want 1", byte_ready); end
        send_byte(8'h01);
        send_word(32'h2008_0005);
        send_byte(8'h05);
        stop_bytes();
        stop_bytes();
        tests++; if (wr_addr.size() != 1) begin fails++; $display("FAIL bad_chk_writes: got %0d want 1", wr_addr.size()); end
        else begin
            tests++; if (wr_addr[0] !== 6'd0) begin fails++; $display("FAIL bad_chk_addr: got %0d want 0", wr_addr[0]); end
            tests++; if (wr_data[0] !== 32'h2008_0005) begin fails++; $display("FAIL bad_chk_data: got %h want 20080005", wr_data[0]); end
        end
        tests++; if (error !== 1'b1) begin fails++; $display("FAIL bad_chk_error: got %b want 1", error); end
        tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL bad_chk_hold: got %b want 1", cpu_hold); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL bad_chk_done: got %b want 0", done); end
    endtask

    task automatic test_good_load();
        wr_addr.delete(); wr_data.delete();
        do_start();
        tests++; if (error !== 1'b0 || word_count !== 7'd0) begin fails++; $display("FAIL restart_clear: error=%b wc=%0d want 0/0", error, word_count); end
        send_byte(8'h01);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00);
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL early_we: got %b want 0", mem_we); end
        send_byte(8'h05);
        // One cycle after the last data byte handshake.
        tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL we_latency: got %b want 1", mem_we); end
        tests++; if (mem_addr !== 6'd0) begin fails++; $display("FAIL good_addr: got %0d want 0", mem_addr); end
        tests++; if (mem_wdata !== 32'h2008_0005) begin fails++; $display("FAIL good_data: got %h want 20080005", mem_wdata); end
        send_byte(8'h2D);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL done_latency: got %b want 1", done); end
        tests++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL good_hold: got %b want 0", cpu_hold); end
        stop_bytes();
        stop_bytes();
        tests++; if (word_count !== 7'd1) begin fails++; $display("FAIL good_wc: got %0d want 1", word_count); end
        tests++; if (wr_addr.size() != 1) begin fails++; $display("FAIL good_writes: got %0d want 1", wr_addr.size()); end
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL good_error: got %b want 0", error); end
    endtask

    task automatic test_full_depth();
        logic [7:0]  chk;
        logic [31:0] w;
        int          n;
        wr_addr.delete(); wr_data.delete();
        chk = 8'h00;
        do_start();
        send_byte(8'd64);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            w = {8'(k), 8'(k) ^ 8'h5A, 8'hC3, ~8'(k)};
            chk = chk ^ xor_word(w);
            for (int i = 3; i >= 0; i--) begin
                if (n % 7 == 3) begin
                    byte_valid = 1'b0;
                    repeat (1 + (n % 3)) @(negedge clk);
                end
                send_byte(w[i*8 +: 8]);
                n++;
            end
        end
        send_byte(chk);
        stop_bytes();
        stop_bytes();
        tests++; if (wr_addr.size() != 64) begin fails++; $display("FAIL full_writes: got %0d want 64", wr_addr.size()); end
        else begin
            for (int k = 0; k < 64; k++) begin
                w = {8'(k), 8'(k) ^ 8'h5A, 8'hC3, ~8'(k)};
                tests++; if (wr_addr[k] !== 6'(k) || wr_data[k] !== w) begin
                    fails++;
                    $display("FAIL full_word%0d: got %0d/%h want %0d/%h", k, wr_addr[k], wr_data[k], k, w);
                end
            end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL full_done: got %b want 1", done); end
        tests++; if (word_count !== 7'd64) begin fails++; $display("FAIL full_wc: got %0d want 64", word_count); end
    endtask

    task automatic test_bad_length();
        logic [7:0] chk;
        wr_addr.delete(); wr_data.delete();
        do_start();
        send_byte(8'd0);
        stop_bytes();
        tests++; if (error !== 1'b1 || byte_ready !== 1'b0) begin fails++; $display("FAIL len0: error=%b ready=%b want 1/0", error, byte_ready); end
        do_start();
        send_byte(8'd65);
        stop_bytes();
        tests++; if (error !== 1'b1 || cpu_hold !== 1'b1) begin fails++; $display("FAIL len65: error=%b hold=%b want 1/1", error, cpu_hold); end
        tests++; if (wr_addr.size() != 0) begin fails++; $display("FAIL badlen_writes: got %0d want 0", wr_addr.size()); end
        chk = xor_word(32'h1122_3344) ^ xor_word(32'hA5A5_0F0F);
        do_start();
        send_byte(8'd2);
        send_word(32'h1122_3344);
        send_word(32'hA5A5_0F0F);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(chk);
        stop_bytes();
        stop_bytes();
        tests++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL recover_done: done=%b error=%b want 1/0", done, error); end
        tests++; if (wr_addr.size() != 2) begin fails++; $display("FAIL recover_writes: got %0d want 2", wr_addr.size()); end
        else begin
            tests++; if (wr_addr[1] !== 6'd1 || wr_data[1] !== 32'hA5A5_0F0F) begin
                fails++; $display("FAIL recover_w1: got %0d/%h want 1/a5a50f0f", wr_addr[1], wr_data[1]);
            end
        end
    endtask

    task automatic test_reset_midload();
        wr_addr.delete(); wr_data.delete();
        do_start();
        send_byte(8'd3);
        send_word(32'hDEAD_BEEF);
        send_byte(8'h77);
        stop_bytes();
        stop_bytes();
        reset = 1'b1;
        #1;
        tests++; if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            fails++; $display("FAIL midreset_flags: hold=%b done=%b error=%b want 1/0/0", cpu_hold, done, error);
        end
        tests++; if (byte_ready !== 1'b0 || word_count !== 7'd0 || mem_we !== 1'b0) begin
            fails++; $display("FAIL midreset_out: ready=%b wc=%0d we=%b want 0/0/0", byte_ready, word_count, mem_we);
        end
        tests++; if (shadow[0] !== 32'hDEAD_BEEF || wr_addr.size() != 1) begin
            fails++; $display("FAIL midreset_mem: got %h (%0d writes) want deadbeef (1)", shadow[0], wr_addr.size());
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL midreset_idle: ready=%b want 0", byte_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0;
        logic [31:0] w1;
        int          c0;
        w0 = 32'h0102_0304;
        w1 = 32'hF0E1_D2C3;
        wr_addr.delete(); wr_data.delete();
        do_start();
        send_byte(8'd2);
        c0 = cyc;
        for (int i = 3; i >= 0; i--) begin
            start = (i == 2);
            send_byte(w0[i*8 +: 8]);
        end
        for (int i = 3; i >= 0; i--) begin
            start = (i == 3);
            send_byte(w1[i*8 +: 8]);
        end
        start = 1'b0;
        send_byte(xor_word(w0) ^ xor_word(w1));
        tests++; if (cyc - c0 != 9) begin fails++; $display("FAIL b2b_cycles: got %0d want 9", cyc - c0); end
        stop_bytes();
        stop_bytes();
        tests++; if (done !== 1'b1 || word_count !== 7'd2) begin fails++; $display("FAIL b2b_done: done=%b wc=%0d want 1/2", done, word_count); end
        tests++; if (wr_addr.size() != 2) begin fails++; $display("FAIL b2b_writes: got %0d want 2", wr_addr.size()); end
        else begin
            tests++; if (wr_data[0] !== w0 || wr_data[1] !== w1 || wr_addr[1] !== 6'd1) begin
                fails++; $display("FAIL b2b_data: got %h %h @%0d want %h %h @1", wr_data[0], wr_data[1], wr_addr[1], w0, w1);
            end
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_bad_checksum();
        test_good_load();
        test_full_depth();
        test_bad_length();
        test_reset_midload();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
